// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encodings and width defaults shared by the sequencer and its benches.
`default_nettype none

package cpu_seq_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_seq_pc_reg.sv
// pc_reg: program counter with async reset, increment and priority load.
`default_nettype none

module pc_reg
    import cpu_seq_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] pc
);

    // Increment wraps naturally at 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle fetch/decode/execute sequencer sharing one memory port
// between instruction fetch and data access; owns PC, IR and MDR.
`default_nettype none

module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            DW       = DEF_DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] mdr,
    output logic [AW-1:0] pc,
    input  logic          cu_r,
    input  logic          cu_w,
    input  logic          cu_stahp,
    input  logic [2:0]    cu_regwrite,
    input  logic [AW-1:0] data_addr,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          reg_we,
    output logic          halted,
    output logic          err,
    output logic [2:0]    state
);

    state_t state_q, state_d;
    logic   pc_inc, pc_load, ir_load, mdr_load, err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            ir      <= '0;
            mdr     <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_load)
                ir <= mem_rdata;
            if (mdr_load)
                mdr <= mem_rdata;
            if (err_set)
                err <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_addr = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        reg_we   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ir_load  = 1'b0;
        mdr_load = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (cu_stahp)
                    state_d = ST_HALT;
                else if (cu_r && cu_w) begin
                    err_set = 1'b1;
                    state_d = ST_HALT;
                end else if (cu_r || cu_w)
                    state_d = ST_MEM;
                else
                    state_d = ST_WB;
            end
            ST_MEM: begin
                // Masking keeps read and write exclusive even if the decoder glitches.
                mem_addr = data_addr;
                mem_rd   = cu_r & ~cu_w;
                mem_wr   = cu_w & ~cu_r;
                if (mem_ack) begin
                    mdr_load = mem_rd;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                reg_we  = |cu_regwrite;
                pc_load = br_taken;
                state_d = ST_FETCH;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_BOOT;
        endcase
    end

    assign halted = (state_q == ST_HALT);
    assign state  = state_q;

    pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (br_target),
        .pc       (pc)
    );

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed table-driven checks of cpu_seq plus multi-cycle corner sequences.
`default_nettype none

module tb_cpu_seq;
    import cpu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr, ir, mdr, pc;
    logic        mem_rd, mem_wr, reg_we, halted, err;
    logic [2:0]  state;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        cu_r = 1'b0, cu_w = 1'b0, cu_stahp = 1'b0, br_taken = 1'b0;
    logic [2:0]  cu_regwrite = '0;
    logic [15:0] data_addr = '0, br_target = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_seq dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .mdr(mdr), .pc(pc),
        .cu_r(cu_r), .cu_w(cu_w), .cu_stahp(cu_stahp), .cu_regwrite(cu_regwrite),
        .data_addr(data_addr), .br_taken(br_taken), .br_target(br_target),
        .reg_we(reg_we), .halted(halted), .err(err), .state(state)
    );

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        r, w, stp;
        logic [2:0]  rw;
        logic [15:0] daddr;
        logic        bt;
        logic [15:0] btgt;
        logic [2:0]  st;
        logic        rd, wr;
        logic [15:0] addr;
        logic        we;
        logic [15:0] pc, ir, mdr;
        logic        err, hlt;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_ack = 0; mem_rdata = '0; cu_r = 0; cu_w = 0; cu_stahp = 0;
        cu_regwrite = '0; data_addr = '0; br_taken = 0; br_target = '0;
    endtask

    // Leaves the bench at a falling edge with reset just released; DUT is in BOOT.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input int i);
        vec_t v;
        v = vecs[i];
        mem_ack = v.ack; mem_rdata = v.rdata; cu_r = v.r; cu_w = v.w; cu_stahp = v.stp;
        cu_regwrite = v.rw; data_addr = v.daddr; br_taken = v.bt; br_target = v.btgt;
        #1;
        chk($sformatf("row%0d state", i), {13'd0, state}, {13'd0, v.st});
        chk($sformatf("row%0d mem_rd", i), {15'd0, mem_rd}, {15'd0, v.rd});
        chk($sformatf("row%0d mem_wr", i), {15'd0, mem_wr}, {15'd0, v.wr});
        chk($sformatf("row%0d mem_addr", i), mem_addr, v.addr);
        chk($sformatf("row%0d reg_we", i), {15'd0, reg_we}, {15'd0, v.we});
        chk($sformatf("row%0d pc", i), pc, v.pc);
        chk($sformatf("row%0d ir", i), ir, v.ir);
        chk($sformatf("row%0d mdr", i), mdr, v.mdr);
        chk($sformatf("row%0d err", i), {15'd0, err}, {15'd0, v.err});
        chk($sformatf("row%0d halted", i), {15'd0, halted}, {15'd0, v.hlt});
        @(negedge clk);
    endtask

    initial begin
        //            ack rdata     r  w  stp rw    daddr     bt btgt       st         rd wr addr      we pc        ir        mdr       err hlt
        vecs[0]  = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_BOOT,   0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0};
        vecs[1]  = '{1, 16'hF001, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_FETCH,  1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0};
        vecs[2]  = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_DECODE, 0, 0, 16'h0000, 0, 16'h0001, 16'hF001, 16'h0000, 0, 0};
        vecs[3]  = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_EXEC,   0, 0, 16'h0000, 0, 16'h0001, 16'hF001, 16'h0000, 0, 0};
        vecs[4]  = '{0, 16'h0000, 0, 0, 0, 3'd1, 16'h0000, 0, 16'h0000, ST_WB,     0, 0, 16'h0000, 1, 16'h0001, 16'hF001, 16'h0000, 0, 0};
        vecs[5]  = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_FETCH,  1, 0, 16'h0001, 0, 16'h0001, 16'hF001, 16'h0000, 0, 0};
        vecs[6]  = '{1, 16'h1234, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_FETCH,  1, 0, 16'h0001, 0, 16'h0001, 16'hF001, 16'h0000, 0, 0};
        vecs[7]  = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_DECODE, 0, 0, 16'h0000, 0, 16'h0002, 16'h1234, 16'h0000, 0, 0};
        vecs[8]  = '{0, 16'h0000, 1, 0, 0, 3'd1, 16'h0040, 0, 16'h0000, ST_EXEC,   0, 0, 16'h0000, 0, 16'h0002, 16'h1234, 16'h0000, 0, 0};
        vecs[9]  = '{0, 16'h0000, 1, 0, 0, 3'd1, 16'h0040, 0, 16'h0000, ST_MEM,    1, 0, 16'h0040, 0, 16'h0002, 16'h1234, 16'h0000, 0, 0};
        vecs[10] = '{0, 16'h0000, 1, 0, 0, 3'd1, 16'h0040, 0, 16'h0000, ST_MEM,    1, 0, 16'h0040, 0, 16'h0002, 16'h1234, 16'h0000, 0, 0};
        vecs[11] = '{1, 16'hBEEF, 1, 0, 0, 3'd1, 16'h0040, 0, 16'h0000, ST_MEM,    1, 0, 16'h0040, 0, 16'h0002, 16'h1234, 16'h0000, 0, 0};
        vecs[12] = '{0, 16'h0000, 1, 0, 0, 3'd1, 16'h0040, 0, 16'h0000, ST_WB,     0, 0, 16'h0000, 1, 16'h0002, 16'h1234, 16'hBEEF, 0, 0};
        vecs[13] = '{1, 16'h2000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_FETCH,  1, 0, 16'h0002, 0, 16'h0002, 16'h1234, 16'hBEEF, 0, 0};
        vecs[14] = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_DECODE, 0, 0, 16'h0000, 0, 16'h0003, 16'h2000, 16'hBEEF, 0, 0};
        vecs[15] = '{0, 16'h0000, 0, 1, 0, 3'd0, 16'h0080, 0, 16'h0000, ST_EXEC,   0, 0, 16'h0000, 0, 16'h0003, 16'h2000, 16'hBEEF, 0, 0};
        vecs[16] = '{1, 16'hDEAD, 0, 1, 0, 3'd0, 16'h0080, 0, 16'h0000, ST_MEM,    0, 1, 16'h0080, 0, 16'h0003, 16'h2000, 16'hBEEF, 0, 0};
        vecs[17] = '{0, 16'h0000, 0, 1, 0, 3'd0, 16'h0080, 1, 16'h0123, ST_WB,     0, 0, 16'h0000, 0, 16'h0003, 16'h2000, 16'hBEEF, 0, 0};
        vecs[18] = '{1, 16'h3000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_FETCH,  1, 0, 16'h0123, 0, 16'h0123, 16'h2000, 16'hBEEF, 0, 0};
        vecs[19] = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_DECODE, 0, 0, 16'h0000, 0, 16'h0124, 16'h3000, 16'hBEEF, 0, 0};
        vecs[20] = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_EXEC,   0, 0, 16'h0000, 0, 16'h0124, 16'h3000, 16'hBEEF, 0, 0};
        vecs[21] = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 1, 16'hFFFF, ST_WB,     0, 0, 16'h0000, 0, 16'h0124, 16'h3000, 16'hBEEF, 0, 0};
        vecs[22] = '{1, 16'h4000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_FETCH,  1, 0, 16'hFFFF, 0, 16'hFFFF, 16'h3000, 16'hBEEF, 0, 0};
        vecs[23] = '{0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_DECODE, 0, 0, 16'h0000, 0, 16'h0000, 16'h4000, 16'hBEEF, 0, 0};
        vecs[24] = '{0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_EXEC,   0, 0, 16'h0000, 0, 16'h0000, 16'h4000, 16'hBEEF, 0, 0};
        vecs[25] = '{1, 16'h5555, 1, 1, 0, 3'd0, 16'h0000, 0, 16'h0000, ST_HALT,   0, 0, 16'h0000, 0, 16'h0000, 16'h4000, 16'hBEEF, 1, 1};

        // Table: ALU, waited fetch, waited load, store+branch, wrap, illegal decode.
        do_reset();
        for (int i = 0; i < 26; i++)
            apply(i);

        // Halt via stahp: no requests for 20 cycles even with ack pulsing.
        do_reset();
        @(negedge clk);                           // FETCH
        mem_ack = 1'b1; mem_rdata = 16'h7000;
        @(negedge clk);                           // DECODE
        mem_ack = 1'b0;
        @(negedge clk);                           // EXEC
        cu_stahp = 1'b1;
        @(negedge clk);
        #1;
        chk("stahp halted", {15'd0, halted}, 16'd1);
        chk("stahp err", {15'd0, err}, 16'd0);
        chk("stahp pc", pc, 16'h0001);
        for (int c = 0; c < 20; c++) begin
            mem_ack = c[0];
            cu_r = c[1];
            cu_w = c[2];
            #1;
            chk($sformatf("halt c%0d req", c), {14'd0, mem_rd, mem_wr}, 16'd0);
            chk($sformatf("halt c%0d state", c), {13'd0, state}, {13'd0, ST_HALT});
            @(negedge clk);
        end

        // Reset while a store is waiting in MEM.
        do_reset();
        @(negedge clk);                           // FETCH
        mem_ack = 1'b1; mem_rdata = 16'h6000;
        @(negedge clk);                           // DECODE
        mem_ack = 1'b0;
        @(negedge clk);                           // EXEC
        cu_w = 1'b1; data_addr = 16'h00A0;
        @(negedge clk);                           // MEM, no ack
        #1;
        chk("midmem wr before", {15'd0, mem_wr}, 16'd1);
        chk("midmem addr before", mem_addr, 16'h00A0);
        chk("midmem pc before", pc, 16'h0001);
        #2;
        rst_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("midmem wr after", {15'd0, mem_wr}, 16'd0);
        chk("midmem addr after", mem_addr, 16'h0000);
        chk("midmem state", {13'd0, state}, {13'd0, ST_BOOT});
        chk("midmem pc", pc, 16'h0000);
        chk("midmem ir", ir, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        #1;
        chk("post reset state", {13'd0, state}, {13'd0, ST_BOOT});
        @(negedge clk);
        #1;
        chk("post reset fetch", {13'd0, state}, {13'd0, ST_FETCH});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
